ivar_select_bank: RTL and testbench
===================================

Name: ivar_select_bank

Overview:
- Parametrised, registered successor to the global controller's single-output iteration-variable mux.
- Holds NUM_CH independently configurable select registers. Each channel picks one iteration variable out of a DIMENSION-wide iteration vector.
- Outputs are presented through a one-deep valid/ready output register that feeds the min/max comparator matrix.
- Configuration is written at runtime; no select signal is driven from outside the block.

Parameters:
- ITERATION_VARIABLE_WIDTH, 16, bit width of each iteration variable (signed).
- DIMENSION, 3, number of iteration variables in the input vector (>=1).
- NUM_CH, 4, number of independent output channels (>=1).
- IDX_W, $clog2(DIMENSION) (min 1), width of a select index.
- CH_W, $clog2(NUM_CH) (min 1), width of a channel address.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_we  input  1  configuration write strobe.
- cfg_ch  input  CH_W  channel being configured.
- cfg_idx  input  IDX_W  iteration-variable index for that channel.
- cfg_en  input  1  channel enable; a disabled channel outputs 0.
- cfg_err  output  1  sticky flag: an illegal configuration write occurred.
- cfg_err_clr  input  1  clears cfg_err.
- in_vec  input  DIMENSION*ITERATION_VARIABLE_WIDTH  iteration vector; element 0 occupies the most-significant slice.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept in_vec this cycle.
- out_vec  output  NUM_CH*ITERATION_VARIABLE_WIDTH  selected variables; channel 0 occupies the most-significant slice.
- out_valid  output  1  out_vec holds a result.
- out_ready  input  1  downstream accepts out_vec.

Behaviour:
- Reset (async assert, sync release):
  - All channel enables = 0 and all indices = 0.
  - out_vec = 0, out_valid = 0, cfg_err = 0.
  - in_ready = 1 from the first cycle after reset.
- Configuration writes:
  - cfg_we=1 with cfg_ch<NUM_CH and cfg_idx<DIMENSION: updates that channel's {idx,en} at the clock edge.
  - cfg_ch>=NUM_CH or cfg_idx>=DIMENSION: the write is ignored and cfg_err is set. Only reachable when the parameter is not a power of two.
  - cfg_err_clr clears cfg_err. If an error write and cfg_err_clr occur in the same cycle, set wins.
- Handshake:
  - in_ready = !out_valid || out_ready. It is combinational and has no dependency on in_valid.
  - A capture happens on a cycle where in_valid && in_ready. At that edge the output register loads the selections and out_valid <= 1.
  - Per-channel selection at capture: channel c loads element cfg_idx[c] if en[c]=1, otherwise 0. Values are passed through unmodified, no sign or width change.
  - If out_valid && out_ready && !in_valid: out_valid <= 0 and out_vec holds its last value.
  - If out_valid && !out_ready: out_vec and out_valid are held stable. in_vec is not sampled.
- Latency and throughput:
  - Latency is 1 cycle from capture to out_valid.
  - Throughput is one vector per cycle while out_ready=1 (back-to-back).
- Configuration/data ordering:
  - A capture uses the configuration registered before the current edge.
  - A cfg write in the same cycle as a capture does not affect that capture; it applies from the next capture onward.
  - Results already held in the output register are never altered by later cfg writes.
- Reset mid-operation: an asserted rst immediately drops out_valid, discards any held result, and clears the configuration.
- No arithmetic; the X-free selection is implemented as AND-OR of the one-hot decoded index.

Decomposition:
- Shared package ivar_sel_pkg:
  - Index/channel width functions (clog2 with min 1).
  - Slice-position helper function for MSB-first packing.
- Sub-module ivar_mux_ch: combinational single-channel selector (in_vec, idx, en -> value) using one-hot AND-OR. It is instantiated NUM_CH times via generate.
- Top level holds the config registers, the error flag, and the output register/handshake.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_vec=0, cfg_err=0 immediately. After release, a capture with no config gives all channels 0.
- Basic selection (DIMENSION=3, NUM_CH=4): write ch0->idx2, ch1->idx0, ch2->idx1 with en=1, leave ch3 disabled; drive in_vec={16'h0005,16'hFFFE,16'h0100} with in_valid=1 -> next cycle out_vec={16'h0100,16'h0005,16'hFFFE,16'h0000}, out_valid=1.
- Backpressure: keep out_ready=0 for 3 cycles while changing in_vec -> out_vec stays stable and in_ready=0. Raising out_ready -> next vector is captured the same cycle and appears the following cycle.
- Config/capture collision: capture in the same cycle as a write ch0 idx2->idx0 -> that result uses idx2 and the next capture uses idx0.
- Illegal write (DIMENSION=3): cfg_idx=3 -> config unchanged and cfg_err=1. Simultaneous illegal write plus cfg_err_clr -> cfg_err stays 1. A clear alone -> 0.
- Streaming: 8 back-to-back vectors with out_ready=1 -> 8 consecutive out_valid cycles in order, no drops or duplicates.

Source files
------------

// File: rtl/ivar_sel_pkg.sv
// Shared helpers for the iteration-variable select bank: index widths and
// MSB-first slice placement used by both the channel mux and the top level.
package ivar_sel_pkg;

  // $clog2 that never returns 0, so a single-entry dimension still gets a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // LSB position of element `pos` in a vector of `count` elements packed MSB-first.
  function automatic int slice_lsb(input int pos, input int count, input int width);
    return (count - 1 - pos) * width;
  endfunction

endpackage

// File: rtl/ivar_mux_ch.sv
// Single-channel iteration-variable selector: one-hot decode of the index,
// then AND-OR over the input elements so no X can leak from unselected slices.
module ivar_mux_ch
  import ivar_sel_pkg::*;
#(
  parameter int W         = 16,
  parameter int DIMENSION = 3,
  parameter int IDX_W     = clog2_min1(DIMENSION)
) (
  input  logic [DIMENSION*W-1:0] in_vec_i,
  input  logic [IDX_W-1:0]       idx_i,
  input  logic                   en_i,
  output logic [W-1:0]           value_o
);

  logic [DIMENSION-1:0] onehot;

  // NOTE: combinational blocks use blocking assignments and assign every output a default first, so no latch is inferred.
  always_comb begin
    onehot  = '0;
    value_o = '0;
    for (int d = 0; d < DIMENSION; d++) begin
      onehot[d] = en_i && (int'(idx_i) == d);
      value_o   = value_o | ({W{onehot[d]}} & in_vec_i[slice_lsb(d, DIMENSION, W) +: W]);
    end
  end

endmodule

// File: rtl/ivar_select_bank.sv
// Bank of runtime-configurable iteration-variable selectors feeding a one-deep
// valid/ready output register towards the min/max comparator matrix.
module ivar_select_bank
  import ivar_sel_pkg::*;
#(
  parameter int ITERATION_VARIABLE_WIDTH = 16,
  parameter int DIMENSION                = 3,
  parameter int NUM_CH                   = 4,
  parameter int IDX_W                    = clog2_min1(DIMENSION),
  parameter int CH_W                     = clog2_min1(NUM_CH)
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       cfg_we,
  input  logic [CH_W-1:0]                            cfg_ch,
  input  logic [IDX_W-1:0]                           cfg_idx,
  input  logic                                       cfg_en,
  output logic                                       cfg_err,
  input  logic                                       cfg_err_clr,
  input  logic [DIMENSION*ITERATION_VARIABLE_WIDTH-1:0] in_vec,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  output logic [NUM_CH*ITERATION_VARIABLE_WIDTH-1:0] out_vec,
  output logic                                       out_valid,
  input  logic                                       out_ready
);

  localparam int W = ITERATION_VARIABLE_WIDTH;

  logic [IDX_W-1:0]    idx_q [NUM_CH];
  logic [NUM_CH-1:0]   en_q;
  logic                cfg_err_q;
  logic [NUM_CH*W-1:0] sel_vec;
  logic [NUM_CH*W-1:0] out_vec_q, out_vec_d;
  logic                out_valid_q, out_valid_d;
  logic                cfg_legal;
  logic                capture;

  // Out-of-range channel/index can only occur for non-power-of-two parameters.
  assign cfg_legal = (int'(cfg_ch) < NUM_CH) && (int'(cfg_idx) < DIMENSION);

  // NOTE: the config array is tiny and must come up cleared, so every entry is reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int c = 0; c < NUM_CH; c++) idx_q[c] <= '0;
    end else if (cfg_we && cfg_legal) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (int'(cfg_ch) == c) begin
          idx_q[c] <= cfg_idx;
          en_q[c]  <= cfg_en;
        end
      end
    end
  end

  // Set has priority over clear when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       cfg_err_q <= 1'b0;
    else if (cfg_we && !cfg_legal) cfg_err_q <= 1'b1;
    else if (cfg_err_clr)          cfg_err_q <= 1'b0;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ivar_mux_ch #(
      .W         (W),
      .DIMENSION (DIMENSION),
      .IDX_W     (IDX_W)
    ) u_mux (
      .in_vec_i (in_vec),
      .idx_i    (idx_q[c]),
      .en_i     (en_q[c]),
      .value_o  (sel_vec[slice_lsb(c, NUM_CH, W) +: W])
    );
  end

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    out_vec_d   = out_vec_q;
    out_valid_d = out_valid_q;
    if (capture) begin
      out_vec_d   = sel_vec;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_vec_q   <= out_vec_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_ivar_select_bank.sv
// Directed self-checking bench for ivar_select_bank with default parameters
// (16-bit variables, DIMENSION=3, NUM_CH=4).
module tb_ivar_select_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_idx;
  logic        cfg_en;
  logic        cfg_err;
  logic        cfg_err_clr;
  logic [47:0] in_vec;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_vec;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  ivar_select_bank dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_ch      (cfg_ch),
    .cfg_idx     (cfg_idx),
    .cfg_en      (cfg_en),
    .cfg_err     (cfg_err),
    .cfg_err_clr (cfg_err_clr),
    .in_vec      (in_vec),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_vec     (out_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] idx, input logic en);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_idx = idx;
    cfg_en  = en;
    tick();
    cfg_we  = 1'b0;
  endtask

  task automatic test_reset();
    // Build up state: one config, sticky error, held output.
    cfg_write(2'd0, 2'd0, 1'b1);
    cfg_write(2'd1, 2'd3, 1'b1);
    in_vec    = {16'h1234, 16'h5678, 16'h9ABC};
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 64'h1234_0000_0000_0000 || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state got v=%b vec=%h err=%b exp v=1 vec=1234000000000000 err=1", out_valid, out_vec, cfg_err);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_vec !== 64'h0 || cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b vec=%h err=%b exp v=0 vec=0 err=0", out_valid, out_vec, cfg_err);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_after_reset got %b exp 1", in_ready);
    end
    in_vec   = {16'h1111, 16'h2222, 16'h3333};
    in_valid = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 64'h0) begin
      errors++;
      $display("FAIL capture_no_config got v=%b vec=%h exp v=1 vec=0", out_valid, out_vec);
    end
    tick();
  endtask

  task automatic test_basic();
    cfg_write(2'd0, 2'd2, 1'b1);
    cfg_write(2'd1, 2'd0, 1'b1);
    cfg_write(2'd2, 2'd1, 1'b1);
    in_vec    = {16'h0005, 16'hFFFE, 16'h0100};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 64'h0100_0005_FFFE_0000) begin
      errors++;
      $display("FAIL basic_select got v=%b vec=%h exp v=1 vec=01000005fffe0000", out_valid, out_vec);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_vec !== 64'h0100_0005_FFFE_0000) begin
      errors++;
      $display("FAIL drain_hold got v=%b vec=%h exp v=0 vec=01000005fffe0000", out_valid, out_vec);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] noise [3];
    noise[0] = {16'hAAAA, 16'hBBBB, 16'hCCCC};
    noise[1] = {16'hDDDD, 16'hEEEE, 16'hFFFF};
    noise[2] = {16'h0F0F, 16'hF0F0, 16'h5A5A};
    out_ready = 1'b0;
    in_vec    = {16'h1111, 16'h2222, 16'h3333};
    in_valid  = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_vec = noise[i];
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 64'h3333_1111_2222_0000) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got rdy=%b v=%b vec=%h exp rdy=0 v=1 vec=3333111122220000",
                 i, in_ready, out_valid, out_vec);
      end
      tick();
    end
    in_vec    = {16'h0001, 16'h0002, 16'h0003};
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready got %b exp 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 64'h0003_0001_0002_0000) begin
      errors++;
      $display("FAIL release_capture got v=%b vec=%h exp v=1 vec=0003000100020000", out_valid, out_vec);
    end
    tick();
  endtask

  task automatic test_collision();
    out_ready = 1'b1;
    in_vec    = {16'h00A0, 16'h00B0, 16'h00C0};
    in_valid  = 1'b1;
    cfg_write(2'd0, 2'd0, 1'b1);
    checks++;
    if (out_vec !== 64'h00C0_00A0_00B0_0000) begin
      errors++;
      $display("FAIL collision_old_cfg got %h exp 00c000a000b00000", out_vec);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_vec !== 64'h00A0_00A0_00B0_0000) begin
      errors++;
      $display("FAIL collision_new_cfg got %h exp 00a000a000b00000", out_vec);
    end
    cfg_write(2'd1, 2'd2, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_vec !== 64'h00A0_00A0_00B0_0000) begin
      errors++;
      $display("FAIL held_vs_cfg got v=%b vec=%h exp v=1 vec=00a000a000b00000", out_valid, out_vec);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    cfg_write(2'd0, 2'd3, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sets_err got %b exp 1", cfg_err);
    end
    cfg_err_clr = 1'b1;
    cfg_write(2'd2, 2'd3, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL set_beats_clear got %b exp 1", cfg_err);
    end
    tick();
    cfg_err_clr = 1'b0;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL clear_alone got %b exp 0", cfg_err);
    end
    in_vec   = {16'h0007, 16'h0008, 16'h0009};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_vec !== 64'h0007_0009_0008_0000) begin
      errors++;
      $display("FAIL illegal_cfg_unchanged got %h exp 0007000900080000", out_vec);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] e0, e1, e2;
    cfg_write(2'd0, 2'd0, 1'b1);
    cfg_write(2'd1, 2'd1, 1'b1);
    cfg_write(2'd2, 2'd2, 1'b1);
    cfg_write(2'd3, 2'd0, 1'b1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      e0 = 16'h0010 + 16'(k);
      e1 = 16'h0020 + 16'(k);
      e2 = 16'h0030 + 16'(k);
      in_vec = {e0, e1, e2};
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_vec !== {e0, e1, e2, e0}) begin
        errors++;
        $display("FAIL stream[%0d] got v=%b vec=%h exp v=1 vec=%h", k, out_valid, out_vec, {e0, e1, e2, e0});
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_end got v=%b exp 0", out_valid);
    end
  endtask

  initial begin
    rst         = 1'b1;
    cfg_we      = 1'b0;
    cfg_ch      = '0;
    cfg_idx     = '0;
    cfg_en      = 1'b0;
    cfg_err_clr = 1'b0;
    in_vec      = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_vec !== 64'h0 || cfg_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL initial_reset got v=%b vec=%h err=%b rdy=%b exp v=0 vec=0 err=0 rdy=1",
               out_valid, out_vec, cfg_err, in_ready);
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_collision();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
